// File: rtl/bsg_fpu_align_pipe.sv
// bsg_fpu_align_pipe: two-stage mantissa alignment right-shifter with sticky.
// S1 does the coarse shift in multiples of 16 bits. S2 does the fine shift of
// 0..15 bits and drives the outputs straight from its flops.
module bsg_fpu_align_pipe #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [5:0]         shamt_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               sticky_o,
  input  logic               yumi_i
);

  // Shifts are done on a 64-bit extension of the data. A shift of 32 or 48
  // then falls off the end naturally, and the sticky mask already covers
  // every data bit, so no special case is needed for shifts >= width_p.
  localparam int XW = 64;

  typedef struct packed {
    logic [width_p-1:0] data;
    logic [3:0]         fine;
    logic               sticky;
  } s1_t;

  typedef struct packed {
    logic [width_p-1:0] data;
    logic               sticky;
  } s2_t;

  // r_vld_pipe[1] is the S1 valid bit, r_vld_pipe[2] is the S2 valid bit.
  logic [2:1]    r_vld_pipe;
  s1_t           r_s1;
  s2_t           r_s2;

  logic          w_acc;
  logic          w_xfer;
  logic [5:0]    w_c_amt;
  logic [XW-1:0] w_c_ext;
  logic [XW-1:0] w_c_mask;
  logic [XW-1:0] w_f_ext;
  logic [XW-1:0] w_f_mask;
  s1_t           w_s1_d;
  s2_t           w_s2_d;

  // Handshake. ready_o depends only on state and yumi_i, never on v_i.
  assign ready_o = ~r_vld_pipe[1] | ~r_vld_pipe[2] | yumi_i;
  assign w_acc   = v_i & ready_o;
  assign w_xfer  = r_vld_pipe[1] & (~r_vld_pipe[2] | yumi_i);

  // Coarse stage: shift by {shamt[5:4],4'b0} and OR together the dropped bits.
  assign w_c_amt       = {shamt_i[5:4], 4'b0000};
  assign w_c_ext       = XW'(data_i);
  assign w_c_mask      = (64'd1 << w_c_amt) - 64'd1;
  assign w_s1_d.data   = width_p'(w_c_ext >> w_c_amt);
  assign w_s1_d.fine   = shamt_i[3:0];
  assign w_s1_d.sticky = |(w_c_ext & w_c_mask);

  // Fine stage: shift by the leftover 0..15 bits and fold the drops into sticky.
  assign w_f_ext       = XW'(r_s1.data);
  assign w_f_mask      = (64'd1 << r_s1.fine) - 64'd1;
  assign w_s2_d.data   = width_p'(w_f_ext >> r_s1.fine);
  assign w_s2_d.sticky = r_s1.sticky | (|(w_f_ext & w_f_mask));

  // Valid bits. An asynchronous reset flushes both stages at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_acc | (r_vld_pipe[1] & r_vld_pipe[2] & ~yumi_i);
      r_vld_pipe[2] <= w_xfer | (r_vld_pipe[2] & ~yumi_i);
    end
  end

  // S1 payload loads on accept and holds otherwise.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_s1 <= '0;
    else if (w_acc)  r_s1 <= w_s1_d;
  end

  // S2 payload loads on transfer. A consumed entry keeps its stale value.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_s2 <= '0;
    else if (w_xfer) r_s2 <= w_s2_d;
  end

  assign v_o      = r_vld_pipe[2];
  assign data_o   = r_s2.data;
  assign sticky_o = r_s2.sticky;

endmodule

// File: tb/tb_bsg_fpu_align_pipe.sv
// Directed bench for bsg_fpu_align_pipe. Inputs are driven on the falling
// edge and outputs are checked on the falling edge, away from the active edge.
module tb_bsg_fpu_align_pipe;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [31:0] data_i;
  logic [5:0]  shamt_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        sticky_o;
  logic        yumi_i;

  int vectors = 0;
  int miscompares = 0;

  bsg_fpu_align_pipe #(.width_p(32)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .shamt_i(shamt_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
    .sticky_o(sticky_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // yumi_i must never be raised while the output is empty.
  always @(posedge clk_i)
    if (reset_n_i && yumi_i)
      assert (v_o === 1'b1) else $error("FAIL yumi_without_v observed v_o=%b required 1", v_o);

  // Bit-serial reference: walk each input bit to its destination or into sticky.
  function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic [5:0] sh);
    logic [31:0] q = '0;
    logic        s = 1'b0;
    for (int i = 0; i < 32; i++)
      if (i < int'(sh)) s = s | d[i];
      else              q[i - int'(sh)] = d[i];
    return {s, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one item into an empty pipe, check it appears after exactly two edges, then consume it.
  task automatic run_one(input logic [31:0] d, input logic [5:0] sh,
                         input logic [31:0] ed, input logic es, input string tag);
    v_i = 1'b1; data_i = d; shamt_i = sh; yumi_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    v_i = 1'b0; data_i = $urandom;
    chk({tag, "_v_early"}, 64'(v_o), 64'd0);
    @(posedge clk_i); @(negedge clk_i);
    chk({tag, "_v"}, 64'(v_o), 64'd1);
    chk({tag, "_data"}, 64'(data_o), 64'(ed));
    chk({tag, "_sticky"}, 64'(sticky_o), 64'(es));
    yumi_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    yumi_i = 1'b0;
    chk({tag, "_v_drain"}, 64'(v_o), 64'd0);
  endtask

  logic [31:0] bd [8];
  logic [5:0]  bs [8];
  logic [31:0] td [100];
  logic [5:0]  ts [100];
  logic [32:0] exp_r;
  logic        acc;
  int          sent, got;

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; shamt_i = '0;

    // Reset with random inputs toggling.
    repeat (3) begin
      @(negedge clk_i);
      v_i = 1'($urandom); data_i = $urandom; shamt_i = 6'($urandom);
    end
    #1;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_sticky", 64'(sticky_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1; v_i = 1'b0;

    // First item right after reset, then boundary and coarse/fine cases.
    run_one(32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF, 1'b0, "first");
    run_one(32'h8000_0001, 6'd1,  32'h4000_0000, 1'b1, "sh1");
    run_one(32'h8000_0001, 6'd31, 32'h0000_0001, 1'b1, "sh31");
    run_one(32'h8000_0001, 6'd32, 32'h0000_0000, 1'b1, "sh32");
    run_one(32'h8000_0001, 6'd63, 32'h0000_0000, 1'b1, "sh63");
    run_one(32'h0001_0000, 6'd16, 32'h0000_0001, 1'b0, "cf16");
    run_one(32'h0001_0000, 6'd17, 32'h0000_0000, 1'b1, "cf17");
    run_one(32'h0001_0000, 6'd15, 32'h0000_0002, 1'b0, "cf15");
    run_one(32'h0000_00F0, 6'd4,  32'h0000_000F, 1'b0, "sh4_clean");
    run_one(32'h0000_0000, 6'd48, 32'h0000_0000, 1'b0, "zero_sh48");

    // Back-pressure: three stalled cycles, then random consumption.
    for (int i = 0; i < 8; i++) begin bd[i] = $urandom; bs[i] = 6'($urandom); end
    bd[0] = 32'h0000_0101; bs[0] = 6'd8;
    sent = 0; got = 0;
    for (int c = 0; c < 400 && got < 8; c++) begin
      yumi_i = (c < 3) ? 1'b0 : (v_o ? 1'($urandom) : 1'b0);
      if (sent < 8) begin v_i = 1'b1; data_i = bd[sent]; shamt_i = bs[sent]; end
      else          v_i = 1'b0;
      #1;
      if (c == 2) begin
        chk("bp_ready_low", 64'(ready_o), 64'd0);
        chk("bp_accepted", 64'(sent), 64'd2);
      end
      if (yumi_i) begin
        exp_r = ref_shift(bd[got], bs[got]);
        chk("bp_data", 64'(data_o), 64'(exp_r[31:0]));
        chk("bp_sticky", 64'(sticky_o), 64'(exp_r[32]));
        got++;
      end
      acc = v_i & ready_o;
      @(posedge clk_i);
      if (acc) sent++;
      @(negedge clk_i);
    end
    v_i = 1'b0; yumi_i = 1'b0;
    chk("bp_count", 64'(got), 64'd8);
    chk("bp_empty", 64'(v_o), 64'd0);

    // Full throughput: one item in and one out every cycle after a 2-cycle fill.
    for (int i = 0; i < 100; i++) begin td[i] = $urandom; ts[i] = 6'($urandom); end
    for (int k = 0; k < 102; k++) begin
      yumi_i = v_o;
      if (k < 100) begin v_i = 1'b1; data_i = td[k]; shamt_i = ts[k]; end
      else         v_i = 1'b0;
      #1;
      chk("tp_ready", 64'(ready_o), 64'd1);
      if (k >= 2) begin
        exp_r = ref_shift(td[k-2], ts[k-2]);
        chk("tp_v", 64'(v_o), 64'd1);
        chk("tp_data", 64'({exp_r[32], exp_r[31:0]}), 64'({exp_r[32], exp_r[31:0]}) ^ 64'({sticky_o, data_o}) ^ 64'({exp_r[32], exp_r[31:0]}));
      end
      @(posedge clk_i); @(negedge clk_i);
    end
    v_i = 1'b0; yumi_i = 1'b0;
    chk("tp_empty", 64'(v_o), 64'd0);

    // Mid-stream reset with both stages full.
    v_i = 1'b1; data_i = 32'hDEAD_BEEF; shamt_i = 6'd3;
    @(posedge clk_i); @(negedge clk_i);
    data_i = 32'h1234_5678; shamt_i = 6'd5;
    @(posedge clk_i); @(negedge clk_i);
    v_i = 1'b0;
    chk("mr_full_v", 64'(v_o), 64'd1);
    chk("mr_full_ready", 64'(ready_o), 64'd0);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mr_v_drop", 64'(v_o), 64'd0);
    chk("mr_ready", 64'(ready_o), 64'd1);
    chk("mr_data", 64'(data_o), 64'd0);
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    run_one(32'h0001_0000, 6'd15, 32'h0000_0002, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bsg_fpu_align_pipe.md
# bsg_fpu_align_pipe

Two-stage, fully pipelined alignment right-shifter for the FP add/sub datapath. It accepts a mantissa and a 6-bit shift amount and produces the right-shifted mantissa together with the sticky bit. The sticky bit is the OR of every bit shifted out. The block sits between exponent-difference logic (upstream) and the mantissa adder (downstream). It uses a valid/ready input and a valid/yumi output.

## Interface
- width_p, 32, mantissa width; shift-amount width is fixed at 6 bits (width_p must be ≤ 32).
- clk_i  input  1  clock; all state updates on rising edge.
- reset_n_i  input  1  reset; asynchronous, active-low.
- v_i  input  1  input valid.
- data_i  input  width_p  unaligned mantissa.
- shamt_i  input  6  right-shift amount, 0..63.
- ready_o  output  1  block can accept input this cycle.
- v_o  output  1  output valid.
- data_o  output  width_p  aligned mantissa.
- sticky_o  output  1  OR of all bits shifted out.
- yumi_i  input  1  consumer takes output this cycle; legal only when v_o=1.

## Operation
- Result definition: data_o = data_i >> shamt_i, with zero fill.
  - If shamt_i ≥ width_p, data_o = 0.
- Sticky definition:
  - sticky_o = OR(data_i[shamt_i-1:0]).
  - If shamt_i = 0, sticky_o = 0.
  - If shamt_i ≥ width_p, sticky_o = OR(data_i).
- Stage 1 (S1), registered on accept (v_i & ready_o):
  - Stores the coarse-shifted data, data_i >> {shamt_i[5:4],4'b0}. This is 0 when shamt_i[5]=1 or when the coarse shift ≥ width_p.
  - Stores the fine amount shamt_i[3:0].
  - Stores the partial sticky: the OR of the bits dropped by the coarse shift. This is OR(data_i) when the coarse shift ≥ width_p.
- Stage 2 (S2), registered on S1→S2 transfer:
  - data = S1 data >> fine amount.
  - sticky = S1 sticky | OR(S1 data[fine-1:0]).
  - S2 drives data_o and sticky_o directly from flops.
- Pipeline valid bits v1 and v2:
  - S1→S2 transfer happens when v1 & (~v2 | yumi_i).
  - ready_o = ~v1 | ~v2 | yumi_i. It is combinational from yumi_i, and there is no combinational path from v_i to ready_o.
  - v2 next = (v1 & (~v2 | yumi_i)) | (v2 & ~yumi_i).
  - v1 next = (v_i & ready_o) | (v1 & v2 & ~yumi_i).
- Data registers load only on their stage's enable and hold otherwise.
- When an entry is consumed with no replacement, the data registers keep their stale contents. v_o qualifies data_o and sticky_o.
- Simultaneous accept, transfer and yumi in one cycle is legal. Throughput is one item per cycle.
- Back-pressure:
  - With yumi_i=0 and both stages full, ready_o=0.
  - No item may be dropped or duplicated.
  - Output order equals input order.

## Timing
- Latency: an item accepted at edge N is visible on v_o/data_o/sticky_o after edge N+1, with an empty pipe and no stall.
- Reset (reset_n_i=0, asynchronous):
  - v1=v2=0, so v_o=0 and ready_o=1.
  - data_o=0 and sticky_o=0. All data and shamt flops clear to 0.
- Reset asserted mid-operation flushes both stages immediately, without waiting for a clock edge. No output is produced for the flushed items.
- Reset deassertion is synchronised externally. The first accept is legal on the first edge with reset_n_i=1.
- yumi_i asserted while v_o=0 is illegal; the bench flags it with an assertion.
- data_o and sticky_o are stable while v_o=1 and yumi_i=0.

## Test plan
- Reset check: hold reset_n_i=0 with random inputs → v_o=0, ready_o=1, data_o=0, sticky_o=0. Then release, send one item (data_i=32'hFFFF_FFFF, shamt_i=0) → v_o=1 two edges later, data_o=32'hFFFF_FFFF, sticky_o=0.
- Boundary shift amounts with data_i=32'h8000_0001:
  - shamt 1 → data_o 32'h4000_0000, sticky_o 1.
  - shamt 31 → data_o 32'h0000_0001, sticky_o 1.
  - shamt 32 → data_o 0, sticky_o 1.
  - shamt 63 → data_o 0, sticky_o 1.
- Coarse/fine split with data_i=32'h0001_0000:
  - shamt 16 → data_o 1, sticky_o 0.
  - shamt 17 → data_o 0, sticky_o 1.
  - shamt 15 → data_o 2, sticky_o 0.
- Back-pressure: stream 8 items with yumi_i=0 → ready_o falls after 2 accepts. Then toggle yumi_i randomly → all 8 results emerge in order, each matching the reference model, with none lost or duplicated.
- Full throughput: v_i=1 and yumi_i=1 every cycle for 100 random items → ready_o stays 1 and one valid output per cycle after a 2-cycle fill.
- Mid-stream reset: pulse reset_n_i low between edges while both stages are full → v_o drops immediately, and the pre-reset items never appear. The next accepted item produces a correct result.
